normalizador_8_seq: RTL and testbench

Iterative 8-bit normalizer: the inverse of the combinational barrel shifter. Given a word, it shifts it one bit per clock toward the selected end until the end bit is 1, and reports the normalized word and the shift count `n`. Feeding `Y` and `n` back through the barrel shifter in the opposite direction reproduces `X`. It sits beside the barrel shifter in the datapath tutorial set and uses a start/done handshake.

---
 rtl/normalizador_8_seq_if.sv | 35 +++
 rtl/normalizador_8_seq.sv | 144 ++++++++++++++
 tb/tb_normalizador_8_seq.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/normalizador_8_seq_if.sv
// -----------------------------------------------------------------------------
// normalizador_8_seq_if
//   Start/done handshake and data bus of the 8-bit iterative normalizer.
//
//   start  requester -> normalizer  request, sampled only while busy = 0
//   X      requester -> normalizer  word to normalize
//   Izq    requester -> normalizer  direction (1: toward bit 7, 0: toward bit 0)
//   Y      normalizer -> requester  normalized word
//   n      normalizer -> requester  number of single-bit shifts applied
//   zero   normalizer -> requester  captured word was 0x00
//   busy   normalizer -> requester  operation in flight (including done cycle)
//   done   normalizer -> requester  one-cycle completion pulse
//
//   master: the requester side. slave: the normalizer side.
// -----------------------------------------------------------------------------
interface normalizador_8_seq_if;
    logic       start;
    logic [7:0] X;
    logic       Izq;
    logic [7:0] Y;
    logic [2:0] n;
    logic       zero;
    logic       busy;
    logic       done;

    modport master (
        output start, X, Izq,
        input  Y, n, zero, busy, done
    );

    modport slave (
        input  start, X, Izq,
        output Y, n, zero, busy, done
    );
endinterface

// File: rtl/normalizador_8_seq.sv
// -----------------------------------------------------------------------------
// normalizador_8_seq
//   Iterative 8-bit normalizer, the inverse of the barrel shifter. Shifts the
//   captured word toward the selected end until the end bit is 1 and reports
//   the normalized word Y and the shift count n. Feeding Y and n back through
//   the barrel shifter in the opposite direction reproduces X.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset (wins over a simultaneous start)
//     bus    normalizador_8_seq_if.slave: start, X, Izq in; Y, n, zero,
//            busy, done out (all outputs registered)
//
//   Build option:
//     NORM_FAST_EN  defined   -> RUN finishes in one cycle using a priority
//                                encoder (leading / trailing zeros) + shift.
//                   undefined -> one bit per cycle, latency n + 1 edges.
// -----------------------------------------------------------------------------
module normalizador_8_seq (
    input  logic                       clk,
    input  logic                       rst_n,
    normalizador_8_seq_if.slave        bus
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t     state;
    logic [7:0] r;
    logic       dir;
    logic [7:0] y_q;
    logic [2:0] n_q;
    logic       zero_q;
    logic       busy_q;
    logic       done_q;

`ifdef NORM_FAST_EN
    logic [2:0] lz;
    logic [2:0] tz;
    logic [2:0] fast_n;
    logic [7:0] fast_y;

    // Leading zeros: the last hit scanning upward is the highest set bit.
    // Trailing zeros: the last hit scanning downward is the lowest set bit.
    always_comb begin
        // NOTE: every output of an always_comb gets a default first, otherwise
        // paths that skip an assignment infer a latch.
        lz = '0;
        tz = '0;
        for (int i = 0; i < 8; i++)
            if (r[i]) lz = 3'(7 - i);
        for (int i = 7; i >= 0; i--)
            if (r[i]) tz = 3'(i);
        fast_n = dir ? lz : tz;
        fast_y = dir ? (r << fast_n) : (r >> fast_n);
    end
`else
    logic [2:0] cnt;
    logic       target_set;

    assign target_set = dir ? r[7] : r[0];
`endif

    // busy stays high through the done cycle even though the state machine
    // is already back in IDLE; the first IDLE cycle only drops busy, which is
    // what gives one idle cycle between back-to-back operations.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state  <= ST_IDLE;
            r      <= '0;
            dir    <= 1'b0;
            y_q    <= '0;
            n_q    <= '0;
            zero_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifndef NORM_FAST_EN
            cnt    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (busy_q) begin
                        busy_q <= 1'b0;
                    end else if (bus.start) begin
                        r      <= bus.X;
                        dir    <= bus.Izq;
                        busy_q <= 1'b1;
                        state  <= ST_RUN;
`ifndef NORM_FAST_EN
                        cnt    <= '0;
`endif
                    end
                end

                ST_RUN: begin
                    if (r == '0) begin
                        y_q    <= '0;
                        n_q    <= '0;
                        zero_q <= 1'b1;
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                    end
`ifdef NORM_FAST_EN
                    else begin
                        y_q    <= fast_y;
                        n_q    <= fast_n;
                        zero_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                    end
`else
                    else if (target_set) begin
                        y_q    <= r;
                        n_q    <= cnt;
                        zero_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                    end else begin
                        // A nonzero word needs at most 7 shifts, so cnt
                        // cannot wrap.
                        r   <= dir ? (r << 1) : (r >> 1);
                        cnt <= cnt + 3'd1;
                    end
`endif
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.Y    = y_q;
    assign bus.n    = n_q;
    assign bus.zero = zero_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_normalizador_8_seq.sv
// -----------------------------------------------------------------------------
// tb_normalizador_8_seq
//   Self-checking bench for normalizador_8_seq. Table of vectors with
//   hand-derived expected results; expectations are queued when a request is
//   driven and popped when done is seen. Hand-written sequences cover a start
//   pulse during RUN and a reset in the middle of an operation.
//   Honours NORM_FAST_EN for the expected latency.
// -----------------------------------------------------------------------------
module tb_normalizador_8_seq;

    logic clk = 1'b0;
    logic rst_n;

    normalizador_8_seq_if bus_if ();

    normalizador_8_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic       izq;
        logic [7:0] y;
        logic [2:0] n;
        logic       z;
    } vec_t;

    typedef struct {
        logic [7:0] y;
        logic [2:0] n;
        logic       z;
        int         lat;
    } exp_t;

    vec_t vecs [16];
    exp_t sb [$];

    int total      = 0;
    int bad        = 0;
    int done_count = 0;

    always @(negedge clk)
        if (bus_if.done === 1'b1) done_count++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Drive one request, wait (bounded) for done, compare against the queued
    // expectation. inject > 0 pulses start with X=0xFF before that edge count
    // after acceptance; the pulse must be ignored.
    task automatic run_op(input logic [7:0] x, input logic izq, input logic [7:0] ey,
                          input logic [2:0] en, input logic ez, input int inject);
        exp_t       e;
        int         edges;
        int         busy_cnt;
        bit         got;
        int         dc0;
        logic [7:0] rt;
        e.y = ey;
        e.n = en;
        e.z = ez;
`ifdef NORM_FAST_EN
        e.lat = 1;
`else
        e.lat = ez ? 1 : int'(en) + 1;
`endif
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.X     = x;
        bus_if.Izq   = izq;
        sb.push_back(e);
        dc0 = done_count;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        bus_if.X     = ~x;
        bus_if.Izq   = ~izq;
        check("busy_after_accept", 32'(bus_if.busy), 32'd1);
        edges    = 0;
        busy_cnt = 0;
        got      = 1'b0;
        while (!got && edges < 20) begin
            if (edges + 1 == inject) begin
                bus_if.start = 1'b1;
                bus_if.X     = 8'hFF;
                bus_if.Izq   = 1'b0;
            end
            @(posedge clk);
            edges++;
            #1;
            bus_if.start = 1'b0;
            if (bus_if.busy === 1'b1) busy_cnt++;
            if (bus_if.done === 1'b1) got = 1'b1;
        end
        check("done_seen", 32'(got), 32'd1);
        if (got) begin
            e = sb.pop_front();
            check("Y", 32'(bus_if.Y), 32'(e.y));
            check("n", 32'(bus_if.n), 32'(e.n));
            check("zero", 32'(bus_if.zero), 32'(e.z));
            check("latency", 32'(edges), 32'(e.lat));
            check("busy_through_done", 32'(busy_cnt), 32'(edges));
            if (!e.z) begin
                rt = izq ? (bus_if.Y >> bus_if.n) : (bus_if.Y << bus_if.n);
                check("round_trip", 32'(rt), 32'(x));
            end
            @(posedge clk);
            #1;
            check("done_one_cycle", 32'(bus_if.done), 32'd0);
            check("busy_released", 32'(bus_if.busy), 32'd0);
            check("Y_held", 32'(bus_if.Y), 32'(e.y));
            check("n_held", 32'(bus_if.n), 32'(e.n));
            check("done_pulses", 32'(done_count - dc0), 32'd1);
        end else begin
            sb.delete();
        end
    endtask

    initial begin
        int dc0;
        int inject_at;

        vecs[0]  = '{8'h01, 1'b1, 8'h80, 3'd7, 1'b0};
        vecs[1]  = '{8'h30, 1'b0, 8'h03, 3'd4, 1'b0};
        vecs[2]  = '{8'h80, 1'b1, 8'h80, 3'd0, 1'b0};
        vecs[3]  = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b1};
        vecs[4]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b1};
        vecs[5]  = '{8'h01, 1'b0, 8'h01, 3'd0, 1'b0};
        vecs[6]  = '{8'h80, 1'b0, 8'h01, 3'd7, 1'b0};
        vecs[7]  = '{8'h30, 1'b1, 8'hC0, 3'd2, 1'b0};
        vecs[8]  = '{8'h5A, 1'b1, 8'hB4, 3'd1, 1'b0};
        vecs[9]  = '{8'h5A, 1'b0, 8'h2D, 3'd1, 1'b0};
        vecs[10] = '{8'h12, 1'b1, 8'h90, 3'd3, 1'b0};
        vecs[11] = '{8'h12, 1'b0, 8'h09, 3'd1, 1'b0};
        vecs[12] = '{8'hFF, 1'b1, 8'hFF, 3'd0, 1'b0};
        vecs[13] = '{8'hFF, 1'b0, 8'hFF, 3'd0, 1'b0};
        vecs[14] = '{8'h02, 1'b1, 8'h80, 3'd6, 1'b0};
        vecs[15] = '{8'h40, 1'b0, 8'h01, 3'd6, 1'b0};

        rst_n        = 1'b0;
        bus_if.start = 1'b0;
        bus_if.X     = 8'h00;
        bus_if.Izq   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_Y", 32'(bus_if.Y), 32'd0);
        check("rst_n", 32'(bus_if.n), 32'd0);
        check("rst_zero", 32'(bus_if.zero), 32'd0);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_done", 32'(bus_if.done), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++)
            run_op(vecs[i].x, vecs[i].izq, vecs[i].y, vecs[i].n, vecs[i].z, 0);

        // start pulse with X=0xFF while the operation is still running
`ifdef NORM_FAST_EN
        inject_at = 1;
`else
        inject_at = 3;
`endif
        run_op(8'h01, 1'b1, 8'h80, 3'd7, 1'b0, inject_at);
        repeat (3) @(posedge clk);
        #1;
        check("ignored_start_idle", 32'(bus_if.busy), 32'd0);

        // reset in the middle of an operation, with start held during reset
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.X     = 8'h04;
        bus_if.Izq   = 1'b1;
        dc0 = done_count;
        @(posedge clk);
        #1;
`ifndef NORM_FAST_EN
        bus_if.start = 1'b0;
        @(posedge clk);
        #1;
        bus_if.start = 1'b1;
`endif
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_Y", 32'(bus_if.Y), 32'd0);
        check("midrst_n", 32'(bus_if.n), 32'd0);
        check("midrst_zero", 32'(bus_if.zero), 32'd0);
        check("midrst_busy", 32'(bus_if.busy), 32'd0);
        check("midrst_done", 32'(bus_if.done), 32'd0);
        bus_if.start = 1'b0;
        rst_n        = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("midrst_no_done", 32'(done_count - dc0), 32'd0);
        check("midrst_still_idle", 32'(bus_if.busy), 32'd0);
        run_op(8'h40, 1'b1, 8'h80, 3'd1, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
